// File: rtl/pcs_tx_ordered_set.sv
// rtl/pcs_tx_ordered_set.sv - 1000BASE-X PCS transmit ordered-set generator (GMII to encoder octets)
module pcs_tx_ordered_set #(
  parameter int CNT_W = 8
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic [7:0]       TXD,
  input  logic             TX_EN,
  input  logic             TX_ER,
  output logic [7:0]       tx_o_set,
  output logic             tx_o_set_k,
  output logic             tx_even,
  output logic             transmitting,
  output logic [CNT_W-1:0] tx_err_cnt
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K_S   = 8'hFB;
  localparam logic [7:0] K_T   = 8'hFD;
  localparam logic [7:0] K_R   = 8'hF7;
  localparam logic [7:0] K_V   = 8'hFE;

  typedef enum logic [6:0] {
    IDLE_K = 7'b0000001,
    IDLE_D = 7'b0000010,
    SOP    = 7'b0000100,
    DATA   = 7'b0001000,
    EPD_T  = 7'b0010000,
    EPD_R1 = 7'b0100000,
    EPD_R2 = 7'b1000000
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       set_d;
  logic             k_d;
  logic             even_d;
  logic             tx_d;
  logic [CNT_W-1:0] cnt_d;

  // State names the octet currently on tx_o_set; next octet is chosen from it.
  always_comb begin
    state_d = IDLE_K;
    set_d   = K28_5;
    k_d     = 1'b1;
    even_d  = ~tx_even;
    cnt_d   = tx_err_cnt;
    case (state_q)
      IDLE_K: begin
        state_d = IDLE_D;
        set_d   = D16_2;
        k_d     = 1'b0;
      end
      IDLE_D: begin
        if (TX_EN) begin
          state_d = SOP;
          set_d   = K_S;
        end
      end
      SOP, DATA: begin
        if (!TX_EN) begin
          state_d = EPD_T;
          set_d   = K_T;
        end else if (TX_ER) begin
          state_d = DATA;
          set_d   = K_V;
          if (tx_err_cnt != {CNT_W{1'b1}}) cnt_d = tx_err_cnt + CNT_W'(1);
        end else begin
          state_d = DATA;
          set_d   = TXD;
          k_d     = 1'b0;
        end
      end
      EPD_T: begin
        state_d = EPD_R1;
        set_d   = K_R;
      end
      EPD_R1: begin
        // A second /R/ pushes the following K28.5 onto an even position.
        if (tx_even) begin
          state_d = EPD_R2;
          set_d   = K_R;
        end
      end
      EPD_R2: begin
        state_d = IDLE_K;
      end
      default: begin
        state_d = IDLE_K;
        even_d  = 1'b1;
      end
    endcase
    tx_d = (state_d == SOP) || (state_d == DATA);
  end

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q      <= IDLE_K;
      tx_o_set     <= K28_5;
      tx_o_set_k   <= 1'b1;
      tx_even      <= 1'b1;
      transmitting <= 1'b0;
      tx_err_cnt   <= '0;
    end else begin
      state_q      <= state_d;
      tx_o_set     <= set_d;
      tx_o_set_k   <= k_d;
      tx_even      <= even_d;
      transmitting <= tx_d;
      tx_err_cnt   <= cnt_d;
    end
  end

endmodule

// File: doc/pcs_tx_ordered_set.md
Name: pcs_tx_ordered_set

Overview:
Transmit ordered-set generator for the 1000BASE-X PCS. It sits directly upstream of the 8b/10b encoder. It converts the GMII transmit interface (TXD/TX_EN/TX_ER) into a stream of one octet per GTX_CLK on tx_o_set, with a K/D flag:
- idle /I2/ pairs (K28.5, D16.2)
- /S/ at start of packet, then data, with /V/ for errors
- /T/ /R/ (or /T/ /R/ /R/) at end of packet, so that idle always restarts on an even code-group position.

Parameters:
CNT_W, 8, width of the saturating /V/ (error-propagation) counter tx_err_cnt.

Ports:
GTX_CLK  input  1  transmit clock; all state is updated on its rising edge.
mr_main_reset  input  1  asynchronous, active-high reset.
TXD  input  8  GMII transmit data octet.
TX_EN  input  1  GMII transmit enable.
TX_ER  input  1  GMII transmit error.
tx_o_set  output  8  octet for the encoder: K28.5=8'hBC, D16.2=8'h50, /S/ K27.7=8'hFB, /T/ K29.7=8'hFD, /R/ K23.7=8'hF7, /V/ K30.7=8'hFE, or data.
tx_o_set_k  output  1  1 = tx_o_set is a K code group; 0 = D code group.
tx_even  output  1  1 = current tx_o_set occupies an even code-group position.
transmitting  output  1  1 while states SOP or DATA are driving the output.
tx_err_cnt  output  CNT_W  count of /V/ octets emitted; saturates at all-ones.

Behaviour:
- Interface: one clock, GTX_CLK. Reset mr_main_reset is asynchronous and active-high.
- While reset is asserted:
  - state=IDLE_K, tx_o_set=8'hBC, tx_o_set_k=1, tx_even=1
  - transmitting=0, tx_err_cnt=0
- All outputs are registered. Inputs sampled at edge n determine the outputs after edge n (1-cycle latency).
- tx_even toggles on every clock after reset release. K28.5 must only ever appear with tx_even=1.
- The state names what was just emitted. Transitions at each rising edge:
  - IDLE_K (K28.5, even): emit 8'h50 (D) -> IDLE_D. TX_EN/TXD are ignored and that octet is dropped.
  - IDLE_D (D16.2, odd):
    - TX_EN=1: emit /S/ 8'hFB (K) -> SOP. /S/ replaces the sampled TXD octet, regardless of TX_ER.
    - otherwise: emit 8'hBC -> IDLE_K.
  - SOP or DATA:
    - TX_EN=1, TX_ER=0: emit TXD (D) -> DATA.
    - TX_EN=1, TX_ER=1: emit /V/ 8'hFE (K) -> DATA, and increment tx_err_cnt unless it is saturated.
    - TX_EN=0: emit /T/ 8'hFD (K) -> EPD_T. TX_ER is ignored.
  - EPD_T: emit /R/ 8'hF7 (K) -> EPD_R1.
  - EPD_R1:
    - if the /R/ just emitted had tx_even=1: emit second /R/ 8'hF7 -> EPD_R2.
    - else: emit 8'hBC -> IDLE_K.
  - EPD_R2: emit 8'hBC -> IDLE_K.
- TX_EN is ignored in EPD_T, EPD_R1 and EPD_R2; carrier extension and back-to-back /S/ are not supported.
- A frame whose TX_EN rises in an IDLE_K cycle loses up to 2 leading preamble octets. This is acceptable.
- transmitting=1 exactly in cycles whose emitted octet comes from state SOP or DATA.
- Reset asserted mid-packet: outputs return immediately to the reset values. No /T/ is generated.
- Illegal or unreachable state encoding: recover to IDLE_K on the next edge, emitting 8'hBC with tx_even forced to 1.
- Implementation: one-hot state register, async-reset flops, combinational next-state/next-output logic with default assignments (no latches).

Test Plan:
1. Reset idle: assert mr_main_reset, release, TX_EN=0 for 8 cycles -> tx_o_set BC,50,BC,50,… with k=1,0,1,0 and tx_even=1,0,1,0. tx_err_cnt=0.
2. Frame with even data count: TX_EN first sampled in IDLE_D, TXD=55,55,D5,0A,0B, then TX_EN=0 -> FB,55,D5,0A,0B,FD,F7,F7,BC.
   - tx_even of FB=1, F7 (first)=1, BC=1.
   - transmitting high for exactly 5 cycles.
3. Odd alignment end: same frame plus one extra octet 0C before TX_EN=0 -> …,0B,0C,FD,F7,BC. Single /R/, BC at tx_even=1.
4. Error propagation: during DATA, TX_ER=1 for 3 cycles with TXD=AA -> three FE octets with k=1, tx_err_cnt=3. With CNT_W=2, five such octets leave tx_err_cnt=3 (saturated).
5. Late TX_EN and ignored re-assert:
   - TX_EN rises in an IDLE_K cycle -> first octet dropped, 50 emitted, then FB.
   - TX_EN re-asserted during EPD_T/EPD_R1 -> no FB until the next IDLE_D.
6. Reset mid-packet: assert mr_main_reset asynchronously between edges during DATA -> outputs go immediately to BC/k=1/tx_even=1/transmitting=0/tx_err_cnt=0. After release, idle resumes with 50 next.
